// File: rtl/seq_alu_pkg.sv
// +----------------------------------------------------------------------+
// | Module : alu_pkg                                                     |
// | Brief  : Op codes, status bit indices and FSM states for seq_alu.    |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  // Operation codes carried on ALUop
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NOT  = 3'b011,
    OP_SHL  = 3'b100,
    OP_ASR  = 3'b101,
    OP_MUL  = 3'b110,
    OP_RSVD = 3'b111
  } alu_op_t;

  // Bit positions inside the Z status vector
  localparam int Z_ZERO = 0;
  localparam int Z_NEG  = 1;
  localparam int Z_OVF  = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_alu_if.sv
// +----------------------------------------------------------------------+
// | Module : seq_alu_if                                                  |
// | Brief  : Operand/request and result/status bundle of seq_alu.        |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

interface seq_alu_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [2:0]       ALUop;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic [WIDTH-1:0] out;
  logic [2:0]       Z;
  logic             busy;
  logic             done;

  // Controller side: issues requests, consumes results
  modport master (
    output start, ALUop, Ain, Bin,
    input  out, Z, busy, done
  );

  // ALU side
  modport slave (
    input  start, ALUop, Ain, Bin,
    output out, Z, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/seq_alu_mul.sv
// +----------------------------------------------------------------------+
// | Module : seq_alu_mul                                                 |
// | Brief  : Unsigned shift-add multiplier, one partial product per step.|
// |          product_lo/ovf reflect the value being written this cycle,  |
// |          so the caller can capture it on the edge of the last step.  |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_alu_mul #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  input  wire logic             step,
  output logic      [WIDTH-1:0] product_lo,
  output logic                  ovf,
  output logic                  finished
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q,   cnt_d;

  // Next-state: load clears the accumulator, each step adds one partial product
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // Multiplier state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign product_lo = acc_d[WIDTH-1:0];
  assign ovf        = |acc_d[2*WIDTH-1:WIDTH];
  assign finished   = step && (cnt_q == CW'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// +----------------------------------------------------------------------+
// | Module : seq_alu                                                     |
// | Brief  : Registered ALU with start/busy/done handshake. Single-cycle |
// |          ops complete on the start edge; MUL iterates WIDTH steps.   |
// |          Build macro SEQ_ALU_MUL_EN enables the iterative multiplier;|
// |          without it op 110 behaves as the reserved op.               |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  seq_alu_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [2:0]       z_q,     z_d;

  logic [WIDTH-1:0] sum, diff, sc_res;
  logic             sc_ovf;
  logic [SHW-1:0]   shamt;

  function automatic logic [2:0] mk_z(input logic [WIDTH-1:0] r, input logic o);
    logic [2:0] z;
    z        = '0;
    z[Z_ZERO] = (r == '0);
    z[Z_NEG]  = r[WIDTH-1];
    z[Z_OVF]  = o;
    return z;
  endfunction

  assign sum   = bus.Ain + bus.Bin;
  assign diff  = bus.Ain - bus.Bin;
  assign shamt = bus.Bin[SHW-1:0];

  // Single-cycle datapath; MUL and reserved fall to zero result, no overflow
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (alu_op_t'(bus.ALUop))
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (bus.Ain[WIDTH-1] == bus.Bin[WIDTH-1]) &&
                 (sum[WIDTH-1] != bus.Ain[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (bus.Ain[WIDTH-1] != bus.Bin[WIDTH-1]) &&
                 (diff[WIDTH-1] != bus.Ain[WIDTH-1]);
      end
      OP_AND:  sc_res = bus.Ain & bus.Bin;
      OP_NOT:  sc_res = ~bus.Bin;
      OP_SHL:  sc_res = bus.Ain << shamt;
      OP_ASR:  sc_res = WIDTH'($signed(bus.Ain) >>> shamt);
      default: sc_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic             mul_load;
  logic             mul_step;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_ovf;
  logic             mul_finished;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .reset      (reset),
    .load       (mul_load),
    .a          (bus.Ain),
    .b          (bus.Bin),
    .step       (mul_step),
    .product_lo (mul_lo),
    .ovf        (mul_ovf),
    .finished   (mul_finished)
  );
`endif

  // Sequencer next-state and result capture; results change only on completion
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    z_d     = z_q;
`ifdef SEQ_ALU_MUL_EN
    mul_load = 1'b0;
    mul_step = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef SEQ_ALU_MUL_EN
          if (alu_op_t'(bus.ALUop) == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = MUL;
          end else begin
            out_d   = sc_res;
            z_d     = mk_z(sc_res, sc_ovf);
            state_d = DONE;
          end
`else
          out_d   = sc_res;
          z_d     = mk_z(sc_res, sc_ovf);
          state_d = DONE;
`endif
        end
      end
      MUL: begin
`ifdef SEQ_ALU_MUL_EN
        mul_step = 1'b1;
        if (mul_finished) begin
          out_d   = mul_lo;
          z_d     = mk_z(mul_lo, mul_ovf);
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      z_q     <= z_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.Z    = z_q;
  assign bus.done = (state_q == DONE);
`ifdef SEQ_ALU_MUL_EN
  assign bus.busy = (state_q == MUL);
`else
  assign bus.busy = 1'b0;
`endif

endmodule

`default_nettype wire
